// File: rtl/mover_derecha_serial.sv
// Sequential right shifter: shifts the captured operand one bit per clock,
// with zero or sign fill, behind a start/busy/done handshake.
module mover_derecha_serial #(
    parameter int WIDTH = 10,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             START,
    input  logic [WIDTH-1:0] SUM_REST,
    input  logic [SHW-1:0]   shiftR,
    input  logic             ARIT,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] DERECHA
);
    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

    // Amounts past the operand width all produce a fully filled word.
    localparam logic [SHW-1:0] CMAX = SHW'(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] w;
    logic [SHW-1:0]   cnt;
    logic             f;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            w       <= '0;
            cnt     <= '0;
            f       <= 1'b0;
            DERECHA <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        w     <= SUM_REST;
                        cnt   <= (shiftR > CMAX) ? CMAX : shiftR;
                        f     <= ARIT & SUM_REST[WIDTH-1];
                        state <= SHIFT;
                        BUSY  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        w   <= {f, w[WIDTH-1:1]};
                        cnt <= cnt - 1'b1;
                    end else begin
                        DERECHA <= w;
                        state   <= FIN;
                        DONE    <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mover_derecha_serial.sv
// Randomized and directed checks of mover_derecha_serial against a
// shift-operator reference model.
module tb_mover_derecha_serial;
    logic       clk = 1'b0;
    logic       reset, START, ARIT;
    logic [9:0] SUM_REST, DERECHA;
    logic [3:0] shiftR;
    logic       BUSY, DONE;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [9:0] prev_res;

    mover_derecha_serial #(.WIDTH(10), .SHW(4)) dut (
        .clk(clk), .reset(reset), .START(START), .SUM_REST(SUM_REST),
        .shiftR(shiftR), .ARIT(ARIT), .BUSY(BUSY), .DONE(DONE), .DERECHA(DERECHA)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] model(input logic [9:0] op, input int amt, input bit arit);
        int n;
        logic signed [9:0] s;
        n = (amt > 10) ? 10 : amt;
        s = op;
        if (arit) return s >>> n;
        return op >> n;
    endfunction

    function automatic int clampn(input int amt);
        return (amt > 10) ? 10 : amt;
    endfunction

    // Issues one request and records what the handshake did; optionally
    // pulses START with junk operands during SHIFT and during FIN.
    task automatic run_op(input logic [9:0] op, input logic [3:0] amt, input bit arit,
                          input bit inject, output int done_cyc, output int busy_cnt,
                          output int done_cnt, output int unstable, output bit timeout);
        @(negedge clk);
        START = 1'b1; SUM_REST = op; shiftR = amt; ARIT = arit;
        @(posedge clk);
        done_cyc = -1; busy_cnt = 0; done_cnt = 0; unstable = 0; timeout = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (BUSY) busy_cnt++;
            if (DONE) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end else if (done_cyc < 0 && DERECHA !== prev_res) begin
                unstable++;
            end
            START    = inject && (cyc == 1 || DONE);
            SUM_REST = 10'($urandom);
            shiftR   = 4'($urandom);
            ARIT     = 1'($urandom);
            if (!BUSY) begin
                timeout = 1'b0;
                break;
            end
        end
        START = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; START = 1'b1; SUM_REST = 10'h3FF; shiftR = 4'd2; ARIT = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({DERECHA, DONE, BUSY} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_state: got DERECHA=%h DONE=%b BUSY=%b, want 0/0/0", DERECHA, DONE, BUSY);
        end
        reset = 1'b0; START = 1'b0;
        @(negedge clk);
        n_checks++;
        if (BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_accept: got BUSY=%b, want 0", BUSY);
        end
        prev_res = 10'h000;
    endtask

    task automatic test_logical();
        int dc, bc, nd, us; bit to;
        run_op(10'b1011001110, 4'd3, 1'b0, 1'b0, dc, bc, nd, us, to);
        n_checks += 4;
        if (to || DERECHA !== 10'b0001011001) begin
            n_fail++; $display("FAIL logical_result: got %b to=%b, want 0001011001", DERECHA, to);
        end
        if (dc !== 4) begin n_fail++; $display("FAIL logical_latency: got %0d, want 4", dc); end
        if (bc !== 5) begin n_fail++; $display("FAIL logical_busy: got %0d, want 5", bc); end
        if (nd !== 1 || us !== 0) begin
            n_fail++; $display("FAIL logical_handshake: done pulses %0d unstable %0d, want 1/0", nd, us);
        end
        prev_res = 10'b0001011001;
    endtask

    task automatic test_arith();
        logic [9:0] ops [2] = '{10'b1000000001, 10'b1000000001};
        bit         ar  [2] = '{1'b1, 1'b0};
        logic [9:0] exp [2] = '{10'b1111100000, 10'b0000100000};
        int dc, bc, nd, us; bit to;
        for (int i = 0; i < 2; i++) begin
            run_op(ops[i], 4'd4, ar[i], 1'b0, dc, bc, nd, us, to);
            n_checks += 2;
            if (to || DERECHA !== exp[i]) begin
                n_fail++; $display("FAIL arith_result[%0d]: got %b, want %b", i, DERECHA, exp[i]);
            end
            if (dc !== 5 || nd !== 1 || us !== 0) begin
                n_fail++; $display("FAIL arith_handshake[%0d]: latency %0d pulses %0d unstable %0d, want 5/1/0", i, dc, nd, us);
            end
            prev_res = exp[i];
        end
    endtask

    task automatic test_boundaries();
        logic [9:0] ops [3] = '{10'h2A5, 10'h3FF, 10'h200};
        logic [3:0] am  [3] = '{4'd0, 4'd15, 4'd12};
        bit         ar  [3] = '{1'b0, 1'b0, 1'b1};
        logic [9:0] exp [3] = '{10'h2A5, 10'h000, 10'h3FF};
        int         lat [3] = '{1, 11, 11};
        int dc, bc, nd, us; bit to;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], am[i], ar[i], 1'b0, dc, bc, nd, us, to);
            n_checks += 3;
            if (to || DERECHA !== exp[i]) begin
                n_fail++; $display("FAIL boundary_result[%0d]: got %h, want %h", i, DERECHA, exp[i]);
            end
            if (dc !== lat[i]) begin
                n_fail++; $display("FAIL boundary_latency[%0d]: got %0d, want %0d", i, dc, lat[i]);
            end
            if (bc !== lat[i] + 1 || nd !== 1) begin
                n_fail++; $display("FAIL boundary_busy[%0d]: busy %0d pulses %0d, want %0d/1", i, bc, nd, lat[i] + 1);
            end
            prev_res = exp[i];
        end
    endtask

    task automatic test_busy_ignore();
        int dc, bc, nd, us; bit to;
        run_op(10'h2F0, 4'd2, 1'b1, 1'b1, dc, bc, nd, us, to);
        n_checks += 2;
        if (to || DERECHA !== 10'h3BC) begin
            n_fail++; $display("FAIL busy_ignore_result: got %h, want 3bc", DERECHA);
        end
        if (nd !== 1 || dc !== 3) begin
            n_fail++; $display("FAIL busy_ignore_done: pulses %0d latency %0d, want 1/3", nd, dc);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0) begin
            n_fail++; $display("FAIL busy_ignore_queued: got BUSY=%b DONE=%b, want 0/0", BUSY, DONE);
        end
        prev_res = 10'h3BC;
    endtask

    task automatic test_abort();
        int dc, bc, nd, us, pulses; bit to;
        @(negedge clk);
        START = 1'b1; SUM_REST = 10'h3C3; shiftR = 4'd8; ARIT = 1'b0;
        @(posedge clk);
        @(negedge clk); START = 1'b0;
        @(negedge clk); reset = 1'b1;
        pulses = 0;
        repeat (2) begin @(negedge clk); if (DONE) pulses++; end
        reset = 1'b0;
        repeat (14) begin @(negedge clk); if (DONE) pulses++; end
        n_checks += 2;
        if (pulses !== 0) begin n_fail++; $display("FAIL abort_done: got %0d pulses, want 0", pulses); end
        if (DERECHA !== 10'h000 || BUSY !== 1'b0) begin
            n_fail++; $display("FAIL abort_state: got DERECHA=%h BUSY=%b, want 000/0", DERECHA, BUSY);
        end
        prev_res = 10'h000;
        run_op(10'h155, 4'd1, 1'b0, 1'b0, dc, bc, nd, us, to);
        n_checks++;
        if (to || DERECHA !== 10'h0AA || dc !== 2 || us !== 0) begin
            n_fail++; $display("FAIL abort_recover: got %h latency %0d, want 0aa/2", DERECHA, dc);
        end
        prev_res = 10'h0AA;
    endtask

    task automatic test_random();
        int dc, bc, nd, us; bit to;
        logic [9:0] op, exp; logic [3:0] am; bit ar;
        for (int i = 0; i < 40; i++) begin
            op = 10'($urandom); am = 4'($urandom_range(0, 15)); ar = 1'($urandom);
            exp = model(op, am, ar);
            run_op(op, am, ar, 1'($urandom), dc, bc, nd, us, to);
            n_checks++;
            if (to || DERECHA !== exp || dc !== clampn(am) + 1 || bc !== clampn(am) + 2
                || nd !== 1 || us !== 0) begin
                n_fail++;
                $display("FAIL random[%0d]: op=%h amt=%0d arit=%b got %h lat %0d busy %0d pulses %0d, want %h lat %0d busy %0d pulses 1",
                         i, op, am, ar, DERECHA, dc, bc, nd, exp, clampn(am) + 1, clampn(am) + 2);
            end
            prev_res = exp;
        end
    endtask

    initial begin
        test_reset();
        test_logical();
        test_arith();
        test_boundaries();
        test_busy_ignore();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
